// File: rtl/clk_div_100.sv
// Integer clock divider: a terminal-count counter toggles a registered clk_out
// every DIVISOR/2 input cycles, giving a 50%-duty output of period DIVISOR cycles.
module clk_div_100 #(
    parameter int DIVISOR = 100
) (
    input  logic clk,
    input  logic reset,
    output logic clk_out
);

    localparam int HALF = DIVISOR / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [CW-1:0] TERMINAL = CW'(HALF - 1);

    if ((DIVISOR < 2) || ((DIVISOR % 2) != 0)) begin : g_bad_divisor
        $error("clk_div_100: DIVISOR must be even and >= 2");
    end

    logic [CW-1:0] cnt;

    // reset is active-low and asynchronous, so even a sub-cycle pulse clears
    // the phase and drops a high clk_out without waiting for a clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else if (cnt == TERMINAL) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
        end else begin
            cnt     <= cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_clk_div_100.sv
// Directed bench for clk_div_100 at DIVISOR=100 and DIVISOR=1000: edge timing,
// duty cycle, mid-run reset and a sub-cycle reset glitch.
`timescale 1ns/1ps
module tb_clk_div_100;

    logic clk = 1'b0;
    logic reset_a;
    logic reset_b;
    logic out_a;
    logic out_b;

    int checks = 0;
    int errors = 0;

    realtime rise_a_q[$];
    realtime fall_a_q[$];
    realtime rise_b_q[$];
    realtime fall_b_q[$];

    int max_cnt_a = 0;
    int max_cnt_b = 0;

    // 100 MHz: rising edges at 5, 15, 25, ... ns
    always #5 clk = ~clk;

    clk_div_100 #(.DIVISOR(100)) u_a (
        .clk     (clk),
        .reset   (reset_a),
        .clk_out (out_a)
    );

    clk_div_100 #(.DIVISOR(1000)) u_b (
        .clk     (clk),
        .reset   (reset_b),
        .clk_out (out_b)
    );

    always @(posedge out_a) rise_a_q.push_back($realtime);
    always @(negedge out_a) fall_a_q.push_back($realtime);
    always @(posedge out_b) rise_b_q.push_back($realtime);
    always @(negedge out_b) fall_b_q.push_back($realtime);

    always @(negedge clk) begin
        if (reset_a === 1'b1 && $realtime < 200500.0 && int'(u_a.cnt) > max_cnt_a)
            max_cnt_a = int'(u_a.cnt);
        if (reset_b === 1'b1 && $realtime < 200500.0 && int'(u_b.cnt) > max_cnt_b)
            max_cnt_b = int'(u_b.cnt);
    end

    task automatic wait_until(input realtime t);
        if (t > $realtime) #(t - $realtime);
    endtask

    task automatic clear_a();
        rise_a_q.delete();
        fall_a_q.delete();
    endtask

    task automatic clear_b();
        rise_b_q.delete();
        fall_b_q.delete();
    endtask

    // Reset held low 0..100 ns; released at 100 ns, between clk edges.
    task automatic test_reset();
        reset_a = 1'b0;
        reset_b = 1'b0;
        #0.001;
        checks++;
        if (out_a !== 1'b0 || out_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_t0: out_a=%b out_b=%b required 0 0", out_a, out_b);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_a !== 1'b0 || out_b !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold_out @%0t: out_a=%b out_b=%b required 0 0",
                         $realtime, out_a, out_b);
            end
            checks++;
            if (u_a.cnt !== 6'd0 || u_b.cnt !== 9'd0) begin
                errors++;
                $display("FAIL reset_hold_cnt @%0t: cnt_a=%0d cnt_b=%0d required 0 0",
                         $realtime, u_a.cnt, u_b.cnt);
            end
        end
        reset_a = 1'b1;
        reset_b = 1'b1;
        clear_a();
        clear_b();
    endtask

    // Release at 100; first edge 105 is edge 1; toggles on edge 50, 100, ...
    // so rises at 595 + 1000*i and falls at 1095 + 1000*i.
    task automatic test_div100_timing();
        wait_until(52700.0);
        checks++;
        if (rise_a_q.size() < 52 || fall_a_q.size() < 52) begin
            errors++;
            $display("FAIL div100_edge_count: rises=%0d falls=%0d required >=52",
                     rise_a_q.size(), fall_a_q.size());
        end else begin
            for (int i = 0; i < 52; i++) begin
                checks++;
                if (rise_a_q[i] != 595.0 + 1000.0 * i) begin
                    errors++;
                    $display("FAIL div100_rise[%0d]: got %0t required %0t",
                             i, rise_a_q[i], 595.0 + 1000.0 * i);
                end
                checks++;
                if (fall_a_q[i] != 1095.0 + 1000.0 * i) begin
                    errors++;
                    $display("FAIL div100_fall[%0d]: got %0t required %0t",
                             i, fall_a_q[i], 1095.0 + 1000.0 * i);
                end
            end
        end
    endtask

    // Edge 500 after release is at 5095; period 10000, high time 5000.
    task automatic test_div1k_timing();
        wait_until(200500.0);
        checks++;
        if (rise_b_q.size() < 20 || fall_b_q.size() < 20) begin
            errors++;
            $display("FAIL div1k_edge_count: rises=%0d falls=%0d required >=20",
                     rise_b_q.size(), fall_b_q.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                checks++;
                if (rise_b_q[i] != 5095.0 + 10000.0 * i) begin
                    errors++;
                    $display("FAIL div1k_rise[%0d]: got %0t required %0t",
                             i, rise_b_q[i], 5095.0 + 10000.0 * i);
                end
                checks++;
                if (fall_b_q[i] != 10095.0 + 10000.0 * i) begin
                    errors++;
                    $display("FAIL div1k_fall[%0d]: got %0t required %0t",
                             i, fall_b_q[i], 10095.0 + 10000.0 * i);
                end
            end
        end
        checks++;
        if (max_cnt_a != 49 || max_cnt_b != 499) begin
            errors++;
            $display("FAIL cnt_wrap_max: max_a=%0d max_b=%0d required 49 499",
                     max_cnt_a, max_cnt_b);
        end
    endtask

    // At 205820 out_a is high (rose 205595). Pulse 205820..205932; first edge
    // after release is 205935, so rises 206425, 207425 and fall 206925.
    task automatic test_midrun_reset_100();
        wait_until(205820.0);
        checks++;
        if (out_a !== 1'b1) begin
            errors++;
            $display("FAIL mid100_pre_high: out_a=%b required 1", out_a);
        end
        reset_a = 1'b0;
        #0.001;
        checks++;
        if (out_a !== 1'b0 || u_a.cnt !== 6'd0) begin
            errors++;
            $display("FAIL mid100_immediate: out_a=%b cnt=%0d required 0 0", out_a, u_a.cnt);
        end
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            checks++;
            if (out_a !== 1'b0 || u_a.cnt !== 6'd0) begin
                errors++;
                $display("FAIL mid100_hold @%0t: out_a=%b cnt=%0d required 0 0",
                         $realtime, out_a, u_a.cnt);
            end
        end
        #2;
        reset_a = 1'b1;
        clear_a();
        wait_until(207500.0);
        checks++;
        if (rise_a_q.size() < 2 || fall_a_q.size() < 1) begin
            errors++;
            $display("FAIL mid100_edge_count: rises=%0d falls=%0d required >=2 >=1",
                     rise_a_q.size(), fall_a_q.size());
        end else begin
            checks++;
            if (rise_a_q[0] != 206425.0 || fall_a_q[0] != 206925.0 || rise_a_q[1] != 207425.0) begin
                errors++;
                $display("FAIL mid100_restart: rise0=%0t fall0=%0t rise1=%0t required 206425 206925 207425",
                         rise_a_q[0], fall_a_q[0], rise_a_q[1]);
            end
        end
    endtask

    // At 218200 out_b is high (rose 215095). Pulse 218200..218312; first edge
    // after release is 218315, so rises 223305, 233305 and fall 228305.
    task automatic test_midrun_reset_1k();
        wait_until(218200.0);
        checks++;
        if (out_b !== 1'b1) begin
            errors++;
            $display("FAIL mid1k_pre_high: out_b=%b required 1", out_b);
        end
        reset_b = 1'b0;
        #0.001;
        checks++;
        if (out_b !== 1'b0 || u_b.cnt !== 9'd0) begin
            errors++;
            $display("FAIL mid1k_immediate: out_b=%b cnt=%0d required 0 0", out_b, u_b.cnt);
        end
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            checks++;
            if (out_b !== 1'b0 || u_b.cnt !== 9'd0) begin
                errors++;
                $display("FAIL mid1k_hold @%0t: out_b=%b cnt=%0d required 0 0",
                         $realtime, out_b, u_b.cnt);
            end
        end
        #2;
        reset_b = 1'b1;
        clear_b();
        wait_until(233400.0);
        checks++;
        if (rise_b_q.size() < 2 || fall_b_q.size() < 1) begin
            errors++;
            $display("FAIL mid1k_edge_count: rises=%0d falls=%0d required >=2 >=1",
                     rise_b_q.size(), fall_b_q.size());
        end else begin
            checks++;
            if (rise_b_q[0] != 223305.0 || fall_b_q[0] != 228305.0 || rise_b_q[1] != 233305.0) begin
                errors++;
                $display("FAIL mid1k_restart: rise0=%0t fall0=%0t rise1=%0t required 223305 228305 233305",
                         rise_b_q[0], fall_b_q[0], rise_b_q[1]);
            end
        end
    endtask

    // 3 ns reset pulse at 234500 while out_a is high (rose 234425); first edge
    // after release is 234505, so cnt=49 at 234990 and rises 234995, 235995.
    task automatic test_glitch();
        wait_until(234500.0);
        checks++;
        if (out_a !== 1'b1) begin
            errors++;
            $display("FAIL glitch_pre_high: out_a=%b required 1", out_a);
        end
        reset_a = 1'b0;
        #0.001;
        checks++;
        if (out_a !== 1'b0) begin
            errors++;
            $display("FAIL glitch_immediate: out_a=%b required 0", out_a);
        end
        #2.999;
        reset_a = 1'b1;
        clear_a();
        wait_until(234990.0);
        checks++;
        if (out_a !== 1'b0 || u_a.cnt !== 6'd49) begin
            errors++;
            $display("FAIL glitch_phase: out_a=%b cnt=%0d required 0 49", out_a, u_a.cnt);
        end
        wait_until(236100.0);
        checks++;
        if (rise_a_q.size() < 2 || fall_a_q.size() < 1) begin
            errors++;
            $display("FAIL glitch_edge_count: rises=%0d falls=%0d required >=2 >=1",
                     rise_a_q.size(), fall_a_q.size());
        end else begin
            checks++;
            if (rise_a_q[0] != 234995.0 || fall_a_q[0] != 235495.0 || rise_a_q[1] != 235995.0) begin
                errors++;
                $display("FAIL glitch_restart: rise0=%0t fall0=%0t rise1=%0t required 234995 235495 235995",
                         rise_a_q[0], fall_a_q[0], rise_a_q[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_div100_timing();
        test_div1k_timing();
        test_midrun_reset_100();
        test_midrun_reset_1k();
        test_glitch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
